stream_arb2x1_rr: RTL and testbench

//   Two-channel round-robin stream arbiter with packet locking; it is the control stage upstream of the 2:1 datapath mux.

---
 rtl/stream_arb_pkg.sv | 17 +
 rtl/stream_arb2x1_rr_if.sv | 27 ++
 rtl/stream_arb2x1_rr_pick2.sv | 21 ++
 rtl/stream_arb2x1_rr.sv | 119 +++++++++++
 tb/tb_stream_arb2x1_rr.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/stream_arb_pkg.sv
// Shared definitions for the two-channel round-robin stream arbiter:
// FSM state encodings, default beat width and a small grant helper.
package stream_arb_pkg;

    localparam int WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT0 = 2'd1,
        ST_GRANT1 = 2'd2
    } arb_state_e;

    function automatic arb_state_e grant_state(input logic idx);
        return idx ? ST_GRANT1 : ST_GRANT0;
    endfunction

endpackage

// File: rtl/stream_arb2x1_rr_if.sv
// Valid/ready packet stream bundle; master drives valid/data/last, slave drives ready.
interface stream_arb2x1_rr_if
    import stream_arb_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) ();

    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;
    logic             last;

    modport master (
        output valid,
        output data,
        output last,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        input  last,
        output ready
    );

endinterface

// File: rtl/stream_arb2x1_rr_pick2.sv
// Combinational two-requester round-robin pick; on contention the channel
// that was not served last wins.
module rr_pick2 (
    input  logic req0_i,
    input  logic req1_i,
    input  logic last_served_i,
    output logic gnt_valid_o,
    output logic gnt_idx_o
);

    always_comb begin
        gnt_valid_o = req0_i | req1_i;
        gnt_idx_o   = 1'b0;
        if (req0_i && req1_i) begin
            gnt_idx_o = ~last_served_i;
        end else if (req1_i) begin
            gnt_idx_o = 1'b1;
        end
    end

endmodule

// File: rtl/stream_arb2x1_rr.sv
// Two-channel round-robin stream arbiter with packet locking and a one-deep
// registered output stage; sel drives the downstream 2:1 datapath mux.
module stream_arb2x1_rr
    import stream_arb_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic               clk,
    input  logic               rst,
    stream_arb2x1_rr_if.slave  in0,
    stream_arb2x1_rr_if.slave  in1,
    stream_arb2x1_rr_if.master out,
    output logic               sel,
    output logic               busy
);

    arb_state_e       state_q, state_d;
    logic             sel_q, sel_d;
    logic             last_served_q, last_served_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;

    logic             gnt_valid, gnt_idx;
    logic             out_free;
    logic             rdy0, rdy1;
    logic             acc0, acc1, load;
    logic [WIDTH-1:0] mux_data;
    logic             mux_last;

    rr_pick2 u_pick (
        .req0_i        (in0.valid),
        .req1_i        (in1.valid),
        .last_served_i (last_served_q),
        .gnt_valid_o   (gnt_valid),
        .gnt_idx_o     (gnt_idx)
    );

    // The output register can take a beat when empty or draining this cycle.
    assign out_free = ~out_valid_q | out.ready;
    assign rdy0     = (state_q == ST_GRANT0) && out_free;
    assign rdy1     = (state_q == ST_GRANT1) && out_free;
    assign acc0     = in0.valid & rdy0;
    assign acc1     = in1.valid & rdy1;
    assign load     = acc0 | acc1;

    assign mux_data = sel_q ? in1.data : in0.data;
    assign mux_last = sel_q ? in1.last : in0.last;

    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        last_served_d = last_served_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt_valid) begin
                    state_d = grant_state(gnt_idx);
                    sel_d   = gnt_idx;
                end
            end
            ST_GRANT0: begin
                if (acc0 && in0.last) begin
                    state_d       = ST_IDLE;
                    last_served_d = 1'b0;
                end
            end
            ST_GRANT1: begin
                if (acc1 && in1.last) begin
                    state_d       = ST_IDLE;
                    last_served_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Load and drain may coincide, which keeps one beat per clock flowing.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = mux_data;
            out_last_d  = mux_last;
        end else if (out.ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            sel_q         <= 1'b0;
            last_served_q <= 1'b1;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_last_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            sel_q         <= sel_d;
            last_served_q <= last_served_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_last_q    <= out_last_d;
        end
    end

    assign in0.ready = rdy0;
    assign in1.ready = rdy1;
    assign out.valid = out_valid_q;
    assign out.data  = out_data_q;
    assign out.last  = out_last_q;
    assign sel       = sel_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_stream_arb2x1_rr.sv
// Directed, table-driven bench for stream_arb2x1_rr: one vector per clock,
// inputs driven on the falling edge, outputs compared shortly after.
module tb_stream_arb2x1_rr;

    localparam int W = 8;

    typedef struct {
        logic         rst;
        logic         v0;
        logic [W-1:0] d0;
        logic         l0;
        logic         v1;
        logic [W-1:0] d1;
        logic         l1;
        logic         ordy;
        logic [13:0]  exp;   // {rdy0, rdy1, out_valid, out_data, out_last, sel, busy}
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sel, busy;

    int n_vec = 0;
    int n_bad = 0;

    vec_t tbl[$];

    stream_arb2x1_rr_if #(.WIDTH(W)) in0_if ();
    stream_arb2x1_rr_if #(.WIDTH(W)) in1_if ();
    stream_arb2x1_rr_if #(.WIDTH(W)) out_if ();

    stream_arb2x1_rr #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .in0  (in0_if),
        .in1  (in1_if),
        .out  (out_if),
        .sel  (sel),
        .busy (busy)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(
        input logic r, input logic v0, input logic [W-1:0] d0, input logic l0,
        input logic v1, input logic [W-1:0] d1, input logic l1, input logic ordy,
        input logic e_r0, input logic e_r1, input logic e_ov, input logic [W-1:0] e_od,
        input logic e_ol, input logic e_sel, input logic e_busy);
        vec_t v;
        v.rst  = r;
        v.v0   = v0;
        v.d0   = d0;
        v.l0   = l0;
        v.v1   = v1;
        v.d1   = d1;
        v.l1   = l1;
        v.ordy = ordy;
        v.exp  = {e_r0, e_r1, e_ov, e_od, e_ol, e_sel, e_busy};
        return v;
    endfunction

    task automatic run(input vec_t v, input string name);
        logic [13:0] act;
        logic [13:0] ex;
        @(negedge clk);
        rst           = v.rst;
        in0_if.valid  = v.v0;
        in0_if.data   = v.d0;
        in0_if.last   = v.l0;
        in1_if.valid  = v.v1;
        in1_if.data   = v.d1;
        in1_if.last   = v.l1;
        out_if.ready  = v.ordy;
        #1;
        act = {in0_if.ready, in1_if.ready, out_if.valid, out_if.data, out_if.last, sel, busy};
        ex  = v.exp;
        n_vec++;
        if (act !== ex) begin
            n_bad++;
            $display("FAIL %s: got rdy0=%b rdy1=%b ov=%b od=%h ol=%b sel=%b busy=%b, expected rdy0=%b rdy1=%b ov=%b od=%h ol=%b sel=%b busy=%b",
                     name, act[13], act[12], act[11], act[10:3], act[2], act[1], act[0],
                     ex[13], ex[12], ex[11], ex[10:3], ex[2], ex[1], ex[0]);
        end
    endtask

    initial begin
        in0_if.valid = 1'b1; in0_if.data = 8'hAA; in0_if.last = 1'b0;
        in1_if.valid = 1'b1; in1_if.data = 8'hBB; in1_if.last = 1'b1;
        out_if.ready = 1'b1;

        // Reset held with both channels requesting: nothing granted.
        for (int i = 0; i < 3; i++)
            run(mk(1, 1,8'hAA,0, 1,8'hBB,1, 1,  0,0,0,8'h00,0,0,0), "reset_hold");
        run(mk(0, 0,8'h00,0, 0,8'h00,0, 1,  0,0,0,8'h00,0,0,0), "reset_release");

        // ch0 three-beat packet A0..A2
        tbl.push_back(mk(0, 1,8'hA0,0, 0,8'h00,0, 1,  0,0,0,8'h00,0,0,0));
        tbl.push_back(mk(0, 1,8'hA0,0, 0,8'h00,0, 1,  1,0,0,8'h00,0,0,1));
        tbl.push_back(mk(0, 1,8'hA1,0, 0,8'h00,0, 1,  1,0,1,8'hA0,0,0,1));
        tbl.push_back(mk(0, 1,8'hA2,1, 0,8'h00,0, 1,  1,0,1,8'hA1,0,0,1));
        tbl.push_back(mk(0, 0,8'h00,0, 0,8'h00,0, 1,  0,0,1,8'hA2,1,0,0));
        tbl.push_back(mk(0, 0,8'h00,0, 0,8'h00,0, 1,  0,0,0,8'hA2,1,0,0));
        // both channels streaming single-beat packets: grants alternate
        tbl.push_back(mk(0, 1,8'h10,1, 1,8'h20,1, 1,  0,0,0,8'hA2,1,0,0));
        tbl.push_back(mk(0, 1,8'h10,1, 1,8'h20,1, 1,  0,1,0,8'hA2,1,1,1));
        tbl.push_back(mk(0, 1,8'h10,1, 1,8'h21,1, 1,  0,0,1,8'h20,1,1,0));
        tbl.push_back(mk(0, 1,8'h10,1, 1,8'h21,1, 1,  1,0,0,8'h20,1,0,1));
        tbl.push_back(mk(0, 1,8'h11,1, 1,8'h21,1, 1,  0,0,1,8'h10,1,0,0));
        tbl.push_back(mk(0, 1,8'h11,1, 1,8'h21,1, 1,  0,1,0,8'h10,1,1,1));
        tbl.push_back(mk(0, 1,8'h11,1, 1,8'h22,1, 1,  0,0,1,8'h21,1,1,0));
        tbl.push_back(mk(0, 1,8'h11,1, 1,8'h22,1, 1,  1,0,0,8'h21,1,0,1));
        tbl.push_back(mk(0, 0,8'h00,0, 0,8'h00,0, 1,  0,0,1,8'h11,1,0,0));
        // ch1 packet D0..D2 with a four-cycle downstream stall
        tbl.push_back(mk(0, 0,8'h00,0, 1,8'hD0,0, 1,  0,0,0,8'h11,1,0,0));
        tbl.push_back(mk(0, 0,8'h00,0, 1,8'hD0,0, 1,  0,1,0,8'h11,1,1,1));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(0, 0,8'h00,0, 1,8'hD1,0, 0,  0,0,1,8'hD0,0,1,1));
        tbl.push_back(mk(0, 0,8'h00,0, 1,8'hD1,0, 1,  0,1,1,8'hD0,0,1,1));
        tbl.push_back(mk(0, 0,8'h00,0, 1,8'hD2,1, 1,  0,1,1,8'hD1,0,1,1));
        tbl.push_back(mk(0, 0,8'h00,0, 0,8'h00,0, 1,  0,0,1,8'hD2,1,1,0));
        // ch0 packet E0..E2 with valid gap while ch1 keeps requesting
        tbl.push_back(mk(0, 1,8'hE0,0, 1,8'hF0,1, 1,  0,0,0,8'hD2,1,1,0));
        tbl.push_back(mk(0, 1,8'hE0,0, 1,8'hF0,1, 1,  1,0,0,8'hD2,1,0,1));
        tbl.push_back(mk(0, 0,8'hE1,0, 1,8'hF0,1, 1,  1,0,1,8'hE0,0,0,1));
        tbl.push_back(mk(0, 0,8'hE1,0, 1,8'hF0,1, 1,  1,0,0,8'hE0,0,0,1));
        tbl.push_back(mk(0, 1,8'hE1,0, 1,8'hF0,1, 1,  1,0,0,8'hE0,0,0,1));
        tbl.push_back(mk(0, 1,8'hE2,1, 1,8'hF0,1, 1,  1,0,1,8'hE1,0,0,1));
        tbl.push_back(mk(0, 0,8'h00,0, 1,8'hF0,1, 1,  0,0,1,8'hE2,1,0,0));
        tbl.push_back(mk(0, 0,8'h00,0, 1,8'hF0,1, 1,  0,1,0,8'hE2,1,1,1));
        tbl.push_back(mk(0, 0,8'h00,0, 0,8'h00,0, 1,  0,0,1,8'hF0,1,1,0));
        tbl.push_back(mk(0, 0,8'h00,0, 0,8'h00,0, 1,  0,0,0,8'hF0,1,1,0));

        foreach (tbl[i]) run(tbl[i], $sformatf("vec%0d", i));

        // ch1 single beat (ch1 becomes last served), then a ch1 packet stalled mid-flight
        run(mk(0, 0,8'h00,0, 1,8'h31,1, 1,  0,0,0,8'hF0,1,1,0), "c1_single_idle");
        run(mk(0, 0,8'h00,0, 1,8'h31,1, 1,  0,1,0,8'hF0,1,1,1), "c1_single_grant");
        run(mk(0, 0,8'h00,0, 1,8'h40,0, 1,  0,0,1,8'h31,1,1,0), "c1_pkt_idle");
        run(mk(0, 0,8'h00,0, 1,8'h40,0, 1,  0,1,0,8'h31,1,1,1), "c1_pkt_grant");
        run(mk(0, 0,8'h00,0, 1,8'h41,0, 0,  0,0,1,8'h40,0,1,1), "c1_pkt_stall");
        // Asynchronous reset mid-packet: outputs clear before any clock edge.
        run(mk(1, 1,8'h50,0, 1,8'h41,0, 0,  0,0,0,8'h00,0,0,0), "rst_async");
        run(mk(1, 1,8'h50,0, 1,8'h41,0, 0,  0,0,0,8'h00,0,0,0), "rst_held");
        run(mk(0, 1,8'h50,0, 1,8'h41,0, 1,  0,0,0,8'h00,0,0,0), "post_rst_idle");
        run(mk(0, 1,8'h50,0, 1,8'h41,0, 1,  1,0,0,8'h00,0,0,1), "post_rst_ch0_wins");
        run(mk(0, 0,8'h00,0, 1,8'h41,0, 1,  1,0,1,8'h50,0,0,1), "post_rst_beat");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
